w_line_packer: RTL and testbench



---
 rtl/w_line_packer.sv | 123 ++++++++++++
 tb/tb_w_line_packer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/w_line_packer.sv
// Packs a full-line AXI W burst into one wide W-queue entry with per-byte strobes.
// Flags bursts whose length differs from BEATS; extra beats of long bursts are dropped.
module w_line_packer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned BEATS      = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         s_wdata,
   input  logic [STRB_WIDTH-1:0]         s_wstrb,
   input  logic                          s_wlast,
   input  logic                          s_wvalid,
   output logic                          s_wready,
   output logic [DATA_WIDTH*BEATS-1:0]   line_data,
   output logic [STRB_WIDTH*BEATS-1:0]   line_strb,
   output logic                          line_err,
   output logic                          line_valid,
   input  logic                          line_ready,
   output logic                          busy
);

   localparam int unsigned CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BEATS - 1);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 accept;
   logic                 handshake;
   logic                 drain_wlast_done;
   logic                 drain_entry_done;

   assign accept    = s_wvalid && s_wready;
   assign handshake = line_valid && line_ready;

   // In DRAIN, a dropped s_wready means WLAST was already taken; a dropped line_valid means the entry left.
   assign drain_wlast_done = !s_wready || (s_wvalid && s_wlast);
   assign drain_entry_done = !line_valid || line_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         cnt        <= '0;
         line_data  <= '0;
         line_strb  <= '0;
         line_err   <= 1'b0;
         line_valid <= 1'b0;
         s_wready   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               s_wready <= 1'b1;
               if (accept) begin
                  // Beat 0 starts a fresh line so short bursts leave zeroed, unstrobed slots.
                  if (cnt == '0) begin
                     line_data <= '0;
                     line_strb <= '0;
                  end
                  line_data[cnt*DATA_WIDTH +: DATA_WIDTH] <= s_wdata;
                  line_strb[cnt*STRB_WIDTH +: STRB_WIDTH] <= s_wstrb;
                  busy <= 1'b1;
                  if (s_wlast) begin
                     state      <= HOLD;
                     s_wready   <= 1'b0;
                     line_valid <= 1'b1;
                     line_err   <= (cnt != LAST_CNT);
                  end else if (cnt == LAST_CNT) begin
                     state      <= DRAIN;
                     line_valid <= 1'b1;
                     line_err   <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_WIDTH'(1);
                  end
               end
            end

            HOLD: begin
               s_wready <= 1'b0;
               if (handshake) begin
                  state      <= FILL;
                  line_valid <= 1'b0;
                  cnt        <= '0;
                  s_wready   <= 1'b1;
                  busy       <= 1'b0;
               end
            end

            DRAIN: begin
               if (drain_wlast_done && drain_entry_done) begin
                  state      <= FILL;
                  line_valid <= 1'b0;
                  cnt        <= '0;
                  s_wready   <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  if (accept && s_wlast) begin
                     s_wready <= 1'b0;
                  end
                  if (handshake) begin
                     line_valid <= 1'b0;
                  end
               end
            end

            default: begin
               state      <= FILL;
               cnt        <= '0;
               line_valid <= 1'b0;
               s_wready   <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_w_line_packer.sv
// Directed and randomized bench for w_line_packer with an entry scoreboard.
module tb_w_line_packer;

   localparam int unsigned DW    = 32;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned BEATS = 8;
   localparam int unsigned LW    = DW * BEATS;
   localparam int unsigned LSW   = SW * BEATS;

   typedef struct {
      logic [LW-1:0]  data;
      logic [LSW-1:0] strb;
      logic           err;
   } entry_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [DW-1:0]  s_wdata;
   logic [SW-1:0]  s_wstrb;
   logic           s_wlast;
   logic           s_wvalid;
   logic           s_wready;
   logic [LW-1:0]  line_data;
   logic [LSW-1:0] line_strb;
   logic           line_err;
   logic           line_valid;
   logic           line_ready;
   logic           busy;

   entry_t sb[$];
   int     checks = 0;
   int     errors = 0;
   int     pushed = 0;
   int     popped = 0;

   w_line_packer #(.DATA_WIDTH(DW), .STRB_WIDTH(SW), .BEATS(BEATS)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_wdata    (s_wdata),
      .s_wstrb    (s_wstrb),
      .s_wlast    (s_wlast),
      .s_wvalid   (s_wvalid),
      .s_wready   (s_wready),
      .line_data  (line_data),
      .line_strb  (line_strb),
      .line_err   (line_err),
      .line_valid (line_valid),
      .line_ready (line_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one beat and hold it until accepted (s_wready sampled mid-cycle).
   task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
      int waited = 0;
      s_wdata  = d;
      s_wstrb  = s;
      s_wlast  = l;
      s_wvalid = 1'b1;
      do begin
         @(negedge clk);
         waited++;
      end while (!s_wready && waited < 200);
      chk("beat_accepted", 256'(s_wready), 256'(1));
      @(posedge clk);
      #1;
      s_wvalid = 1'b0;
      s_wlast  = 1'b0;
   endtask

   // Send an n-beat burst and push the entry the packer should produce.
   task automatic send_burst(input int n, input logic [DW-1:0] base, input logic [SW-1:0] s,
                             input bit rnd);
      logic [DW-1:0] d[16];
      entry_t        e;
      e.data = '0;
      e.strb = '0;
      for (int i = 0; i < n; i++) begin
         d[i] = rnd ? DW'($urandom) : base + DW'(i);
         if (i < int'(BEATS)) begin
            e.data[i*DW +: DW] = d[i];
            e.strb[i*SW +: SW] = s;
         end
      end
      e.err = (n != int'(BEATS));
      sb.push_back(e);
      pushed++;
      for (int i = 0; i < n; i++) begin
         if (rnd && $urandom_range(1) == 1) begin
            s_wvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         send_beat(d[i], s, i == n - 1);
      end
   endtask

   // Scoreboard: every entry handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && line_valid && line_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_entry: observed data %h expected no entry", line_data);
         end
         if (sb.size() != 0) begin
            entry_t e;
            e = sb.pop_front();
            popped++;
            chk("sb_data", 256'(line_data), 256'(e.data));
            chk("sb_strb", 256'(line_strb), 256'(e.strb));
            chk("sb_err", 256'(line_err), 256'(e.err));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LW-1:0]  held_data;
      logic [LSW-1:0] held_strb;

      rst = 1'b1; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; line_ready = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wready", 256'(s_wready), 256'(0));
      chk("rst_valid", 256'(line_valid), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_data", 256'(line_data), 256'(0));
      chk("rst_err", 256'(line_err), 256'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("wready_after_rst", 256'(s_wready), 256'(1));

      // Nominal burst
      line_ready = 1'b1;
      send_burst(8, 32'h1000_0000, 4'hF, 1'b0);
      chk("nom_valid", 256'(line_valid), 256'(1));
      chk("nom_beat0", 256'(line_data[31:0]), 256'(32'h1000_0000));
      chk("nom_beat7", 256'(line_data[255:224]), 256'(32'h1000_0007));
      chk("nom_strb", 256'(line_strb), 256'(32'hFFFF_FFFF));
      chk("nom_err", 256'(line_err), 256'(0));
      @(posedge clk); #1;
      chk("nom_valid_drop", 256'(line_valid), 256'(0));

      // Backpressure for 5 cycles
      line_ready = 1'b0;
      send_burst(8, 32'h2000_0000, 4'hF, 1'b0);
      held_data = line_data;
      held_strb = line_strb;
      chk("bp_data0", 256'(held_data[31:0]), 256'(32'h2000_0000));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", 256'(line_valid), 256'(1));
         chk("bp_wready", 256'(s_wready), 256'(0));
         chk("bp_data_stable", 256'(line_data), 256'(held_data));
         chk("bp_strb_stable", 256'(line_strb), 256'(held_strb));
      end
      @(posedge clk); #1;
      line_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_wready_after_hs", 256'(s_wready), 256'(1));
      chk("bp_valid_after_hs", 256'(line_valid), 256'(0));

      // Short burst
      send_burst(3, 32'hA000_0000, 4'h3, 1'b0);
      chk("short_err", 256'(line_err), 256'(1));
      chk("short_strb", 256'(line_strb), 256'(32'h0000_0333));
      chk("short_upper_zero", 256'(line_data[255:96]), 256'(0));
      @(posedge clk); #1;

      // Long burst, entry drains while extra beats arrive
      send_burst(10, 32'hB000_0000, 4'hF, 1'b0);
      chk("long_wready_after", 256'(s_wready), 256'(1));
      chk("long_busy_after", 256'(busy), 256'(0));
      chk("long_valid_after", 256'(line_valid), 256'(0));

      // Long burst where WLAST arrives before the entry is taken
      line_ready = 1'b0;
      send_burst(9, 32'hC000_0000, 4'hF, 1'b0);
      chk("long2_wready_held", 256'(s_wready), 256'(0));
      chk("long2_valid_held", 256'(line_valid), 256'(1));
      chk("long2_err", 256'(line_err), 256'(1));
      chk("long2_busy", 256'(busy), 256'(1));
      line_ready = 1'b1;
      @(posedge clk); #1;
      chk("long2_wready_resume", 256'(s_wready), 256'(1));
      chk("long2_busy_clear", 256'(busy), 256'(0));

      // Reset after beat 4 discards the partial line
      for (int i = 0; i < 5; i++) send_beat(32'hDEAD_0000 + 32'(i), 4'hF, 1'b0);
      chk("partial_busy", 256'(busy), 256'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_wready", 256'(s_wready), 256'(0));
      chk("midrst_busy", 256'(busy), 256'(0));
      chk("midrst_valid", 256'(line_valid), 256'(0));
      rst = 1'b0;
      send_burst(8, 32'h3000_0000, 4'hF, 1'b0);
      chk("post_rst_beat0", 256'(line_data[31:0]), 256'(32'h3000_0000));
      chk("post_rst_err", 256'(line_err), 256'(0));

      // Back-to-back bursts with random valid gaps
      for (int b = 0; b < 20; b++) send_burst(8, '0, 4'(b), 1'b1);

      repeat (5) @(posedge clk);
      #1;
      chk("sb_empty", 256'(sb.size()), 256'(0));
      chk("entry_count", 256'(popped), 256'(pushed));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
